datapath_sequencer: RTL and testbench

Program sequencer that sits directly upstream of the datapath. Holds a small loadable program memory, fetches one instruction at a time, and drives the datapath control ports (Op, WA, RAA, RAB, Sel, Wen). Uses the datapath's Flag output for conditional branches. Ctrl and InPort are driven elsewhere.

---
 rtl/datapath_sequencer_pkg.sv | 52 +++++
 rtl/datapath_sequencer_if.sv | 37 +++
 rtl/datapath_sequencer_prog_mem.sv | 37 +++
 rtl/datapath_sequencer.sv | 149 ++++++++++++++
 tb/tb_datapath_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_sequencer_pkg.sv
// ============================================================================
// datapath_sequencer_pkg : shared types and field positions for the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package datapath_sequencer_pkg;

  localparam int INSTR_W = 24;

  // Bit positions of the 24-bit instruction word
  localparam int CLS_LSB = 20;
  localparam int OP_LSB  = 17;
  localparam int WA_LSB  = 13;
  localparam int RAA_LSB = 9;
  localparam int RAB_LSB = 5;
  localparam int SEL_LSB = 1;
  localparam int WEN_BIT = 0;

  typedef enum logic [3:0] {
    CLS_ALU  = 4'd0,
    CLS_JMP  = 4'd1,
    CLS_BRF  = 4'd2,
    CLS_BRNF = 4'd3,
    CLS_HALT = 4'd4
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] wa;
    logic [3:0] raa;
    logic [3:0] rab;
    logic [3:0] sel;
    logic       wen;
  } ctrl_t;

  // Class codes 5..15 are NOPs, so cls stays a raw nibble rather than the enum
  typedef struct packed {
    logic [3:0] cls;
    ctrl_t      ctrl;
  } instr_t;

endpackage

`default_nettype wire

// File: rtl/datapath_sequencer_if.sv
// ============================================================================
// datapath_sequencer_if : program-load, run-control and datapath control bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface datapath_sequencer_if #(
  parameter int AW = 8
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [23:0]   prog_wdata;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          Flag;
  logic [2:0]    Op;
  logic [3:0]    WA;
  logic [3:0]    RAA;
  logic [3:0]    RAB;
  logic [3:0]    Sel;
  logic          Wen;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output prog_we, prog_addr, prog_wdata, start, start_addr, Flag,
    input  Op, WA, RAA, RAB, Sel, Wen, busy, done, err
  );

  modport slave (
    input  prog_we, prog_addr, prog_wdata, start, start_addr, Flag,
    output Op, WA, RAA, RAB, Sel, Wen, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/datapath_sequencer_prog_mem.sv
// ============================================================================
// seq_prog_mem : single-port synchronous program RAM with registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_prog_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 24
) (
  input  wire logic          clk,
  input  wire logic          we,
  input  wire logic          re,
  input  wire logic [AW-1:0] addr,
  input  wire logic [W-1:0]  wdata,
  output logic      [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Contents are deliberately not reset so a program survives rst
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/datapath_sequencer.sv
// ============================================================================
// datapath_sequencer : fetch/execute program sequencer driving datapath controls
// Rev 1.0
// ============================================================================
`default_nettype none

module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = 256,
  parameter int MAX_INSTR  = 1024
) (
  input wire logic             clk,
  input wire logic             rst,
  datapath_sequencer_if.slave  bus
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int CW = $clog2(MAX_INSTR + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INSTR);

  seq_state_e      state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  ctrl_t           ctrl_q, ctrl_d;

  logic [INSTR_W-1:0] mem_rdata;
  instr_t             instr;
  logic [AW-1:0]      target;
  logic [AW-1:0]      pc_inc;
  logic [CW-1:0]      cnt_inc;
  logic               busy;
  logic               start_ok;
  logic               fetch_go;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;

  assign instr    = instr_t'(mem_rdata);
  assign target   = mem_rdata[AW-1:0];
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign start_ok = bus.start && !busy;
  assign pc_inc   = pc_q + AW'(1);
  assign cnt_inc  = cnt_q + CW'(1);

  // The read for the next instruction is issued on the edge entering FETCH,
  // so the word is already on mem_rdata while FETCH loads the control regs.
  assign mem_addr = fetch_go ? pc_d : bus.prog_addr;
  assign mem_we   = bus.prog_we && !busy && !start_ok;

  seq_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (AW),
    .W     (INSTR_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (fetch_go),
    .addr  (mem_addr),
    .wdata (bus.prog_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    done_d   = 1'b0;
    ctrl_d   = '0;
    fetch_go = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_ok) begin
          state_d  = ST_FETCH;
          pc_d     = bus.start_addr;
          cnt_d    = '0;
          err_d    = 1'b0;
          fetch_go = 1'b1;
        end
      end

      ST_FETCH: begin
        state_d = ST_EXEC;
        if (instr.cls == CLS_ALU) begin
          ctrl_d = instr.ctrl;
        end
      end

      ST_EXEC: begin
        cnt_d = cnt_inc;
        case (instr.cls)
          CLS_JMP:  pc_d = target;
          CLS_BRF:  pc_d = bus.Flag ? target : pc_inc;
          CLS_BRNF: pc_d = bus.Flag ? pc_inc : target;
          CLS_HALT: pc_d = pc_q;
          default:  pc_d = pc_inc;
        endcase

        if (instr.cls == CLS_HALT) begin
          state_d = ST_HALT;
          done_d  = 1'b1;
        end else if (cnt_inc == MAX_CNT) begin
          state_d = ST_HALT;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d  = ST_FETCH;
          fetch_go = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.Op   = ctrl_q.op;
  assign bus.WA   = ctrl_q.wa;
  assign bus.RAA  = ctrl_q.raa;
  assign bus.RAB  = ctrl_q.rab;
  assign bus.Sel  = ctrl_q.sel;
  assign bus.Wen  = ctrl_q.wen;
  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
// ============================================================================
// tb_datapath_sequencer : directed stimulus with a cycle-trace reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_datapath_sequencer;

  localparam int PROG_DEPTH = 256;
  localparam int MAX_INSTR  = 16;

  localparam logic [23:0] W_HALT = 24'h400000;
  localparam logic [23:0] W_NOP  = 24'h500000;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] wa;
    logic [3:0] raa;
    logic [3:0] rab;
    logic [3:0] sel;
    logic       wen;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  datapath_sequencer_if #(.AW(8)) bus ();

  datapath_sequencer #(
    .PROG_DEPTH (PROG_DEPTH),
    .MAX_INSTR  (MAX_INSTR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [23:0] m_mem [PROG_DEPTH];
  obs_t        exp_q [$];
  obs_t        cur;
  logic        m_err;
  logic        m_on;

  // Expand one run into the per-cycle outputs it must produce: two cycles per
  // instruction, then a single done cycle.
  task automatic build_trace(input logic [7:0] a, input logic f);
    logic [7:0]  pc;
    logic [23:0] w;
    logic [3:0]  c;
    obs_t        e;
    pc = a;
    for (int n = 1; n <= MAX_INSTR; n++) begin
      w = m_mem[pc];
      c = w[23:20];
      e = obs_t'({20'd0, 3'b100});
      exp_q.push_back(e);
      e = (c == 4'd0) ? obs_t'({w[19:0], 3'b100}) : obs_t'({20'd0, 3'b100});
      exp_q.push_back(e);
      if (c == 4'd4) begin
        e = obs_t'({20'd0, 3'b010});
        exp_q.push_back(e);
        return;
      end
      if (n == MAX_INSTR) begin
        e = obs_t'({20'd0, 3'b011});
        exp_q.push_back(e);
        return;
      end
      case (c)
        4'd1:    pc = w[7:0];
        4'd2:    pc = f ? w[7:0] : pc + 8'd1;
        4'd3:    pc = f ? pc + 8'd1 : w[7:0];
        default: pc = pc + 8'd1;
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < PROG_DEPTH; i++) m_mem[i] = W_HALT;
    m_on  = 1'b0;
    m_err = 1'b0;
    cur   = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_err = 1'b0;
      cur   = '0;
      m_on  = 1'b1;
    end else begin
      if (bus.start && !cur.busy) begin
        build_trace(bus.start_addr, bus.Flag);
      end else if (bus.prog_we && !cur.busy) begin
        m_mem[bus.prog_addr] = bus.prog_wdata;
      end
      if (exp_q.size() > 0) begin
        cur   = exp_q.pop_front();
        m_err = cur.err;
      end else begin
        cur     = '0;
        cur.err = m_err;
      end
    end
  end

  always @(negedge clk) begin
    obs_t act;
    if (m_on) begin
      act = {bus.Op, bus.WA, bus.RAA, bus.RAB, bus.Sel, bus.Wen,
             bus.busy, bus.done, bus.err};
      checks++;
      if (act !== cur) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got %h expected %h", $time, act, cur);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [23:0] alu(input logic [2:0] op, input logic [3:0] wa,
                                      input logic [3:0] raa, input logic [3:0] rab,
                                      input logic [3:0] sel, input logic wen);
    return {4'd0, op, wa, raa, rab, sel, wen};
  endfunction

  function automatic logic [23:0] br(input logic [3:0] cls, input logic [7:0] tgt);
    return {cls, 12'd0, tgt};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    @(posedge clk);
    #2;
    bus.prog_we    = 1'b1;
    bus.prog_addr  = a;
    bus.prog_wdata = d;
    @(posedge clk);
    #2;
    bus.prog_we = 1'b0;
  endtask

  // Returns 2 time units into the cycle right after the accepting edge
  task automatic go(input logic [7:0] a);
    @(posedge clk);
    #2;
    bus.start      = 1'b1;
    bus.start_addr = a;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(nm, 0, 1);
    @(negedge clk);
  endtask

  function automatic int ctrl_word();
    return int'({bus.Op, bus.WA, bus.RAA, bus.RAB, bus.Sel, bus.Wen});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_wdata = '0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.Flag       = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_ctrl", ctrl_word(), 0);
    chk("reset_done_err", int'({bus.done, bus.err}), 0);

    // ALU then HALT
    wr(8'd0, alu(3'd0, 4'd3, 4'd1, 4'd2, 4'd5, 1'b1));
    wr(8'd1, W_HALT);
    go(8'd0);
    @(negedge clk);
    chk("t1_fetch_busy", int'(bus.busy), 1);
    chk("t1_fetch_wen", int'(bus.Wen), 0);
    @(negedge clk);
    chk("t1_exec_ctrl", ctrl_word(), int'(20'b000_0011_0001_0010_0101_1));
    @(negedge clk);
    chk("t1_wen_one_cycle", int'(bus.Wen), 0);
    @(negedge clk);
    chk("t1_halt_exec_done", int'(bus.done), 0);
    @(negedge clk);
    chk("t1_done_busy_err", int'({bus.done, bus.busy, bus.err}), 3'b100);
    @(negedge clk);
    chk("t1_done_pulse", int'(bus.done), 0);

    // Conditional branches
    wr(8'd0, alu(3'd1, 4'd1, 4'd0, 4'd0, 4'd0, 1'b1));
    wr(8'd1, br(4'd2, 8'd5));
    wr(8'd2, alu(3'd2, 4'd2, 4'd0, 4'd0, 4'd0, 1'b1));
    wr(8'd3, W_HALT);
    wr(8'd5, alu(3'd3, 4'd7, 4'd0, 4'd0, 4'd0, 1'b1));
    wr(8'd6, W_HALT);
    bus.Flag = 1'b1;
    go(8'd0);
    repeat (6) @(negedge clk);
    chk("brf_taken_wa", int'(bus.WA), 7);
    wait_done("brf_taken_done");
    bus.Flag = 1'b0;
    go(8'd0);
    repeat (6) @(negedge clk);
    chk("brf_not_taken_wa", int'(bus.WA), 2);
    wait_done("brf_not_taken_done");
    wr(8'd1, br(4'd3, 8'd5));
    go(8'd0);
    repeat (6) @(negedge clk);
    chk("brnf_taken_wa", int'(bus.WA), 7);
    wait_done("brnf_taken_done");

    // PC wrap from 255 to 0
    wr(8'd255, W_NOP);
    wr(8'd0, W_HALT);
    go(8'd255);
    repeat (4) @(negedge clk);
    chk("wrap_busy", int'(bus.busy), 1);
    @(negedge clk);
    chk("wrap_done", int'(bus.done), 1);
    @(negedge clk);

    // Instruction budget exhaustion
    wr(8'd0, br(4'd1, 8'd0));
    go(8'd0);
    repeat (32) @(negedge clk);
    chk("budget_not_yet", int'(bus.done), 0);
    @(negedge clk);
    chk("budget_done_err", int'({bus.done, bus.err}), 2'b11);
    @(negedge clk);
    chk("budget_err_sticky", int'({bus.done, bus.err}), 2'b01);
    wr(8'd3, W_HALT);
    go(8'd3);
    @(negedge clk);
    chk("start_clears_err", int'(bus.err), 0);
    wait_done("budget_clear_done");

    // Reset in the middle of an ALU EXEC
    wr(8'd0, alu(3'd5, 4'd9, 4'd1, 4'd1, 4'd1, 1'b1));
    wr(8'd1, alu(3'd6, 4'd10, 4'd2, 4'd2, 4'd2, 1'b1));
    wr(8'd2, W_HALT);
    go(8'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_exec_wen", int'(bus.Wen), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_wen_busy_done", int'({bus.Wen, bus.busy, bus.done}), 0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_done", int'(bus.done), 0);
    end
    go(8'd0);
    repeat (2) @(negedge clk);
    chk("rst_rerun_wa", int'(bus.WA), 9);
    wait_done("rst_rerun_done");

    // Writes and starts while busy are dropped
    wr(8'd0, alu(3'd7, 4'd10, 4'd3, 4'd3, 4'd3, 1'b1));
    go(8'd0);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 8'd0;
    bus.prog_wdata = W_HALT;
    bus.start      = 1'b1;
    bus.start_addr = 8'd2;
    repeat (2) @(posedge clk);
    #2;
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    wait_done("busy_write_done");

    // Write and start together: start wins, write dropped
    @(posedge clk);
    #2;
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 8'd0;
    bus.prog_wdata = W_HALT;
    bus.start      = 1'b1;
    bus.start_addr = 8'd0;
    @(posedge clk);
    #2;
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    repeat (2) @(negedge clk);
    chk("write_start_same_cycle_wa", int'(bus.WA), 10);
    wait_done("write_start_done");

    go(8'd0);
    repeat (2) @(negedge clk);
    chk("readback_after_busy_write", int'(bus.WA), 10);
    wait_done("readback_done");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
